// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the VGA timing / paddle logic and the ball motion controller.
// The master drives the counters, paddles and serve; the slave returns the ball state.
interface ball_motion_ctrl_if;
    logic [11:0] i_hcount;
    logic [10:0] i_vcount;
    logic [10:0] i_pad_l_y;
    logic [10:0] i_pad_r_y;
    logic        i_serve;
    logic [11:0] o_ball_x;
    logic [10:0] o_ball_y;
    logic        o_ball_live;
    logic        o_score_l;
    logic        o_score_r;

    modport master (
        output i_hcount, i_vcount, i_pad_l_y, i_pad_r_y, i_serve,
        input  o_ball_x, o_ball_y, o_ball_live, o_score_l, o_score_r
    );

    modport slave (
        input  i_hcount, i_vcount, i_pad_l_y, i_pad_r_y, i_serve,
        output o_ball_x, o_ball_y, o_ball_live, o_score_l, o_score_r
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// Pong ball sequencer: advances the ball once per frame at the start of vertical
// blanking, bounces off walls and paddles, and reports misses as one-cycle pulses.
module ball_motion_ctrl #(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 600,
    parameter int BALL_SIZE   = 20,
    parameter int SPEED       = 2,
    parameter int PAD_L_X     = 20,
    parameter int PAD_R_X     = 770,
    parameter int PAD_W       = 10,
    parameter int PAD_H       = 80,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ball_motion_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_SCORE = 2'd2
    } state_t;

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    // All geometry is carried in 13 bits so sums past the screen edge cannot wrap.
    localparam logic [12:0] L_HA     = 13'(H_ACTIVE);
    localparam logic [12:0] L_VA     = 13'(V_ACTIVE);
    localparam logic [12:0] L_BS     = 13'(BALL_SIZE);
    localparam logic [12:0] L_SPD    = 13'(SPEED);
    localparam logic [12:0] L_PH     = 13'(PAD_H);
    localparam logic [12:0] L_FACE_L = 13'(PAD_L_X + PAD_W);
    localparam logic [12:0] L_FACE_R = 13'(PAD_R_X);
    localparam logic [11:0] L_CX     = 12'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] L_CY     = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [HW-1:0] L_HOLD_LAST = HW'(HOLD_FRAMES - 1);

    state_t        r_state;
    logic [11:0]   r_ball_x;
    logic [10:0]   r_ball_y;
    logic          r_dir_x;       // 1 = right
    logic          r_dir_y;       // 1 = down
    logic [HW-1:0] r_hold;
    logic          r_scorer_left;
    logic          r_live;
    logic          r_score_l;
    logic          r_score_r;

    state_t        w_state_nxt;
    logic [11:0]   w_x_nxt;
    logic [10:0]   w_y_nxt;
    logic          w_dx_nxt;
    logic          w_dy_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_scorer_nxt;
    logic          w_miss_l;
    logic          w_miss_r;
    logic          w_tick;
    logic [12:0]   w_x;
    logic [12:0]   w_y;
    logic [12:0]   w_pl;
    logic [12:0]   w_pr;
    logic          w_ovl_l;
    logic          w_ovl_r;

    assign w_tick  = (bus.i_hcount == 12'd0) && (bus.i_vcount == 11'(V_ACTIVE));
    assign w_x     = {1'b0, r_ball_x};
    assign w_y     = {2'b00, r_ball_y};
    assign w_pl    = {2'b00, bus.i_pad_l_y};
    assign w_pr    = {2'b00, bus.i_pad_r_y};
    assign w_ovl_l = ((w_y + L_BS) > w_pl) && (w_y < (w_pl + L_PH));
    assign w_ovl_r = ((w_y + L_BS) > w_pr) && (w_y < (w_pr + L_PH));

    // Next-state and next-position decision, applied by the register block on frame_tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_ball_x;
        w_y_nxt      = r_ball_y;
        w_dx_nxt     = r_dir_x;
        w_dy_nxt     = r_dir_y;
        w_hold_nxt   = r_hold;
        w_scorer_nxt = r_scorer_left;
        w_miss_l     = 1'b0;
        w_miss_r     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_x_nxt = L_CX;
                w_y_nxt = L_CY;
                if (bus.i_serve) begin
                    w_state_nxt = S_MOVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MOVE: begin
                if (!r_dir_y) begin
                    if (w_y <= L_SPD) begin
                        w_y_nxt  = 11'd0;
                        w_dy_nxt = 1'b1;
                    end else begin
                        w_y_nxt = 11'(w_y - L_SPD);
                    end
                end else begin
                    if ((w_y + L_BS + L_SPD) >= L_VA) begin
                        w_y_nxt  = 11'(L_VA - L_BS);
                        w_dy_nxt = 1'b0;
                    end else begin
                        w_y_nxt = 11'(w_y + L_SPD);
                    end
                end
                // Paddle hit is tested before the miss so a grazing contact still returns.
                if (!r_dir_x) begin
                    if ((w_x >= L_FACE_L) && ((w_x - L_SPD) <= L_FACE_L) && w_ovl_l) begin
                        w_x_nxt  = 12'(L_FACE_L);
                        w_dx_nxt = 1'b1;
                    end else if (w_x <= L_SPD) begin
                        w_x_nxt      = 12'd0;
                        w_miss_l     = 1'b1;
                        w_scorer_nxt = 1'b0;
                        w_hold_nxt   = '0;
                        w_state_nxt  = S_SCORE;
                    end else begin
                        w_x_nxt = 12'(w_x - L_SPD);
                    end
                end else begin
                    if (((w_x + L_BS) <= L_FACE_R) && ((w_x + L_BS + L_SPD) >= L_FACE_R) && w_ovl_r) begin
                        w_x_nxt  = 12'(L_FACE_R - L_BS);
                        w_dx_nxt = 1'b0;
                    end else if ((w_x + L_BS + L_SPD) >= L_HA) begin
                        w_x_nxt      = 12'(L_HA - L_BS);
                        w_miss_r     = 1'b1;
                        w_scorer_nxt = 1'b1;
                        w_hold_nxt   = '0;
                        w_state_nxt  = S_SCORE;
                    end else begin
                        w_x_nxt = 12'(w_x + L_SPD);
                    end
                end
            end
            S_SCORE: begin
                if (r_hold == L_HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_x_nxt     = L_CX;
                    w_y_nxt     = L_CY;
                    w_dx_nxt    = ~r_scorer_left;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_x_nxt     = L_CX;
                w_y_nxt     = L_CY;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // State and ball registers; pulses follow the tick by one cycle and self-clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_ball_x      <= L_CX;
            r_ball_y      <= L_CY;
            r_dir_x       <= 1'b1;
            r_dir_y       <= 1'b1;
            r_hold        <= '0;
            r_scorer_left <= 1'b0;
            r_live        <= 1'b0;
            r_score_l     <= 1'b0;
            r_score_r     <= 1'b0;
        end else begin
            r_score_l <= w_tick && w_miss_r;
            r_score_r <= w_tick && w_miss_l;
            if (w_tick) begin
                r_state       <= w_state_nxt;
                r_ball_x      <= w_x_nxt;
                r_ball_y      <= w_y_nxt;
                r_dir_x       <= w_dx_nxt;
                r_dir_y       <= w_dy_nxt;
                r_hold        <= w_hold_nxt;
                r_scorer_left <= w_scorer_nxt;
                r_live        <= (w_state_nxt == S_MOVE);
            end else begin
                r_state <= r_state;
            end
        end
    end

    assign bus.o_ball_x    = r_ball_x;
    assign bus.o_ball_y    = r_ball_y;
    assign bus.o_ball_live = r_live;
    assign bus.o_score_l   = r_score_l;
    assign bus.o_score_r   = r_score_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomised frame-by-frame play of ball_motion_ctrl against a velocity-based pong model.
module tb_ball_motion_ctrl;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    ball_motion_ctrl_if bus ();

    ball_motion_ctrl dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position plus signed velocity, 0=idle 1=play 2=score-hold.
    int mx, my, vx, vy, mst, mhold;
    bit right_scored;
    bit exp_sl, exp_sr;
    int n_scores = 0;
    bit did_rst = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 390; my = 290; vx = 2; vy = 2; mst = 0; mhold = 0;
        right_scored = 1'b0; exp_sl = 1'b0; exp_sr = 1'b0;
    endtask

    function automatic bit touches(input int y, input int p);
        return (y + 20 > p) && (y < p + 80);
    endfunction

    task automatic model_step(input int pl, input int pr, input bit srv);
        int ny, nvy, nx, nvx;
        exp_sl = 1'b0; exp_sr = 1'b0;
        if (mst == 0) begin
            mx = 390; my = 290;
            if (srv) mst = 1;
        end else if (mst == 1) begin
            ny = my + vy; nvy = vy;
            if (ny <= 0)   begin ny = 0;   nvy = 2;  end
            if (ny >= 580) begin ny = 580; nvy = -2; end
            nx = mx + vx; nvx = vx;
            if (vx < 0) begin
                if (mx >= 30 && mx - 2 <= 30 && touches(my, pl)) begin
                    nx = 30; nvx = 2;
                end else if (nx <= 0) begin
                    nx = 0; mst = 2; mhold = 0; exp_sr = 1'b1; right_scored = 1'b1;
                end
            end else begin
                if (mx + 20 <= 770 && mx + 22 >= 770 && touches(my, pr)) begin
                    nx = 750; nvx = -2;
                end else if (nx >= 780) begin
                    nx = 780; mst = 2; mhold = 0; exp_sl = 1'b1; right_scored = 1'b0;
                end
            end
            mx = nx; my = ny; vx = nvx; vy = nvy;
            if (mst == 2) n_scores++;
        end else begin
            mhold++;
            if (mhold == 60) begin
                mst = 0; mhold = 0; mx = 390; my = 290;
                vx = right_scored ? 2 : -2;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_x"},    int'(bus.o_ball_x),    mx);
        check({tag, "_y"},    int'(bus.o_ball_y),    my);
        check({tag, "_live"}, int'(bus.o_ball_live), (mst == 1) ? 1 : 0);
        check({tag, "_sl"},   int'(bus.o_score_l),   int'(exp_sl));
        check({tag, "_sr"},   int'(bus.o_score_r),   int'(exp_sr));
    endtask

    task automatic set_non_tick();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0: begin
                bus.i_hcount = 12'd0;
                bus.i_vcount = 11'($urandom_range(0, 627));
                if (bus.i_vcount == 11'd600) bus.i_vcount = 11'd601;
            end
            1: begin
                bus.i_hcount = 12'($urandom_range(1, 1055));
                bus.i_vcount = 11'd600;
            end
            2: begin
                bus.i_hcount = 12'($urandom_range(1, 4095));
                bus.i_vcount = 11'($urandom_range(0, 2047));
            end
            default: begin
                bus.i_hcount = 12'd0;
                bus.i_vcount = 11'd599;
            end
        endcase
    endtask

    function automatic int pick_pad();
        int p;
        if ($urandom_range(0, 1) == 0) begin
            p = my - 79 + int'($urandom_range(0, 110));
        end else begin
            p = int'($urandom_range(0, 520));
        end
        if (p < 0) p = 0;
        if (p > 520) p = 520;
        return p;
    endfunction

    // One frame: a few blanking-free cycles, one tick, then a cycle to see the pulse clear.
    task automatic run_frame(input bit force_serve, input bit far_pads);
        int n_pre;
        bus.i_serve   = force_serve ? 1'b1 : ($urandom_range(0, 9) < 7);
        bus.i_pad_l_y = far_pads ? 11'd0 : 11'(pick_pad());
        bus.i_pad_r_y = far_pads ? 11'd0 : 11'(pick_pad());
        n_pre = $urandom_range(1, 3);
        for (int k = 0; k < n_pre; k++) begin
            set_non_tick();
            @(posedge i_clk);
            exp_sl = 1'b0; exp_sr = 1'b0;
            #1;
            check_outputs("hold");
        end
        bus.i_hcount = 12'd0;
        bus.i_vcount = 11'd600;
        @(posedge i_clk);
        model_step(int'(bus.i_pad_l_y), int'(bus.i_pad_r_y), bus.i_serve);
        #1;
        check_outputs("tick");
        set_non_tick();
        @(posedge i_clk);
        exp_sl = 1'b0; exp_sr = 1'b0;
        #1;
        check_outputs("post");
    endtask

    initial begin
        bus.i_hcount  = 12'd5;
        bus.i_vcount  = 11'd0;
        bus.i_pad_l_y = 11'd0;
        bus.i_pad_r_y = 11'd0;
        bus.i_serve   = 1'b0;
        model_reset();
        #23;
        check_outputs("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Launch tick, then three moving frames from centre.
        for (int f = 0; f < 4; f++) run_frame(1'b1, 1'b1);
        check("serve3_x", int'(bus.o_ball_x), 396);
        check("serve3_y", int'(bus.o_ball_y), 296);
        check("serve3_live", int'(bus.o_ball_live), 1);

        for (int f = 0; f < 2500; f++) begin
            if (!did_rst && f >= 300 && mst == 1) begin
                @(posedge i_clk);
                #2;
                i_rst = 1'b1;
                #1;
                model_reset();
                check_outputs("async_rst");
                @(negedge i_clk);
                i_rst = 1'b0;
                did_rst = 1'b1;
            end
            run_frame(1'b0, 1'b0);
        end
        check("rst_done", int'(did_rst), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
